// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 lines, deframes
// 11-bit frames, checks parity/stop, and buffers good bytes in a small FIFO.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       valid,
    input  logic       ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_f, clk_f_d;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          push;
    logic [7:0]    push_data;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop, wr_en, full;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clock;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock only follows the synced line after FILTER_LEN stable disagreeing cycles.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            flt_cnt <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_s2 != clk_f) begin
                if (flt_cnt == FLT_MAX) begin
                    clk_f   <= clk_s2;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            push       <= 1'b0;
            push_data  <= '0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            push       <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift <= {dat_s2, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        // Odd parity: data plus parity bit must hold an odd number of ones.
                        if (!(^{shift, par_bit})) begin
                            parity_err <= 1'b1;
                        end else if (!dat_s2) begin
                            frame_err <= 1'b1;
                        end else begin
                            push      <= 1'b1;
                            push_data <= shift;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_MAX) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                shift     <= '0;
                tmo_cnt   <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign busy  = (state != IDLE);
    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = valid & ready;
    assign wr_en = push & (~full | pop);

    // Valid/ready: the head byte transfers in any cycle where valid and ready are both high.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        scancode = 8'd0;
        if (valid) begin
            scancode = mem[rd_ptr];
        end
    end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
PS/2 device-to-host receiver that sits directly upstream of the keyboard command decoder. It samples the raw ps2_clock/ps2_data lines, deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop), and checks each frame. Good bytes are buffered in a small FIFO and presented as scancode/valid. The decoder consumes one byte per valid cycle (ready tied high) and handles F0/E0 prefixes itself.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized samples required before the filtered ps2_clock changes
TIMEOUT_CYCLES, 100000, clk_in cycles without a filtered falling edge before a partial frame is aborted (2 ms at 50 MHz)
FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2

Ports:
clk_in  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset
ps2_clock  input  1  raw PS/2 clock line, asynchronous
ps2_data  input  1  raw PS/2 data line, asynchronous
scancode  output  8  FIFO head byte; valid only while valid=1
valid  output  1  FIFO non-empty
ready  input  1  consumer accepts head byte when valid&&ready
parity_err  output  1  1-cycle pulse: frame rejected for bad parity
frame_err  output  1  1-cycle pulse: stop bit 0, or timeout abort
overflow  output  1  sticky: a good byte was dropped because the FIFO was full; cleared only by reset
busy  output  1  receive FSM not in IDLE

Behaviour:
- Reset (reset=0, async): sync flops and filtered clock = 1; FSM = IDLE; FIFO empty; scancode=0, valid=0, parity_err=0, frame_err=0, overflow=0, busy=0.
- Synchronizer: two flops each on ps2_clock and ps2_data.
- Glitch filter: counter increments while synced clock != filtered clock and clears otherwise. On reaching FILTER_LEN-1, filtered clock takes the synced value and the counter clears. Pulses shorter than FILTER_LEN cycles are ignored.
- fall = filtered clock was 1 last cycle and is 0 now. Data is sampled from synced ps2_data in the fall cycle.
- FSM, advancing only on fall:
  - IDLE: data=0 -> DATA with bit_cnt=0. data=1 -> stay in IDLE, no error.
  - DATA: shift register shifts right with the new bit into bit 7. After the 8th bit (bit_cnt=7) -> PARITY.
  - PARITY: latch the bit -> STOP.
  - STOP: parity_ok = XOR(data byte, parity bit) = 1.
    - parity bad: pulse parity_err, regardless of the stop bit.
    - parity ok and stop=0: pulse frame_err.
    - otherwise: push the byte.
    - Always -> IDLE.
- Timeout: cycle counter clears on every fall and in IDLE. In DATA/PARITY/STOP, reaching TIMEOUT_CYCLES-1 -> pulse frame_err, discard the partial byte, go to IDLE.
- Error pulses are exactly one cycle, in the cycle after the decision edge.
- FIFO:
  - Push occurs in the cycle after the stop-bit fall. valid rises the following cycle, giving 2-cycle latency from the stop fall to valid.
  - Pop on valid&&ready. scancode is the combinational head from a registered array; it is 0 when empty.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push on full without a pop: drop the new byte and set overflow. FIFO contents are unchanged.
- With ready=1, each good byte produces exactly one valid-high cycle; back-to-back frames never merge.
- busy = (state != IDLE).

Test Plan:
- ready=1; send 0x1C, parity 0, stop 1, 60-cycle half-period -> one valid cycle with scancode=0x1C; parity_err, frame_err, overflow stay 0.
- Send 0xF0 (parity 1) then 0x5A (parity 1) back-to-back -> two separate single-cycle valids, 0xF0 then 0x5A.
- Send 0x5A with parity 0 -> one parity_err pulse, no valid. Send 0x1C with stop 0 -> one frame_err pulse, no valid.
- Send start plus 4 data bits, then idle for TIMEOUT_CYCLES -> frame_err pulse, busy drops. A following 0x1C frame is received correctly.
- Inject 3-cycle low glitches on ps2_clock while idle and mid-frame of 0x1C -> no state change; byte = 0x1C.
- ready=0; send 0x01..0x05 -> overflow=1 after the 5th frame. Then ready=1 -> valid for 0x01, 0x02, 0x03, 0x04 in order, then valid=0. Assert reset mid-frame -> all outputs return to reset values.
